// File: rtl/nonrestoring_div_if.sv
// Start/operand/result bundle between the multdiv operand latch and the divider.
interface nonrestoring_div_if #(
    parameter int WIDTH = 32
);
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;

    modport master (
        output ctrl_DIV, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY
    );

    modport slave (
        input  ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY
    );
endinterface

// File: rtl/nonrestoring_div.sv
// Radix-2 non-restoring signed divider: one WIDTH+1 bit add/subtract per cycle
// through a prefix carry-lookahead adder; quotient truncates toward zero.
module nonrestoring_div_cla #(
    parameter int N = 33
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum
);
    function automatic logic [N-1:0] cla_add(input logic [N-1:0] x,
                                             input logic [N-1:0] y,
                                             input logic         c0);
        logic [N-1:0] prop;
        logic [N-1:0] g;
        logic [N-1:0] p;
        logic [N-1:0] g_prev;
        logic [N-1:0] p_prev;
        logic [N-1:0] carry;
        prop = x ^ y;
        p    = prop;
        g    = x & y;
        // Fold the carry-in into bit 0 so every group generate is a true carry-out.
        g[0] = g[0] | (p[0] & c0);
        for (int d = 1; d < N; d = d * 2) begin
            g_prev = g;
            p_prev = p;
            for (int i = d; i < N; i++) begin
                g[i] = g_prev[i] | (p_prev[i] & g_prev[i-d]);
                p[i] = p_prev[i] & p_prev[i-d];
            end
        end
        carry = {g[N-2:0], c0};
        return prop ^ carry;
    endfunction

    assign sum = cla_add(a, b, cin);
endmodule

module nonrestoring_div #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32    // must equal WIDTH
) (
    input  logic              clock,
    input  logic              reset,
    nonrestoring_div_if.slave bus
);
    localparam int CW = $clog2(ITER);

    // IDLE: waiting for start | RUN: one quotient bit per edge | DONE: RDY cycle
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   rem;
    logic [WIDTH:0]   dvs;
    logic [WIDTH-1:0] quo;
    logic             neg;

    logic [WIDTH-1:0] result;
    logic             exc;
    logic             rdy;

    logic             start;
    logic             zero_div;
    logic             last_iter;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   addend;
    logic [WIDTH:0]   rem_new;
    logic [WIDTH-1:0] quo_new;
    logic [WIDTH-1:0] quo_signed;

    assign start     = bus.ctrl_DIV;
    assign zero_div  = (bus.data_operandB == '0);
    assign last_iter = (cnt == CW'(ITER - 1));

    // Unary minus wraps the most negative value onto itself, read back as unsigned.
    assign abs_a = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
    assign abs_b = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

    assign rem_shift = {rem[WIDTH-1:0], quo[WIDTH-1]};
    assign addend    = rem[WIDTH] ? dvs : ~dvs;

    nonrestoring_div_cla #(.N(WIDTH + 1)) u_cla (
        .a   (rem_shift),
        .b   (addend),
        .cin (~rem[WIDTH]),
        .sum (rem_new)
    );

    assign quo_new    = {quo[WIDTH-2:0], ~rem_new[WIDTH]};
    assign quo_signed = neg ? -quo_new : quo_new;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = zero_div ? DONE : RUN;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                RUN:     if (last_iter) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt    <= '0;
            rem    <= '0;
            dvs    <= '0;
            quo    <= '0;
            neg    <= 1'b0;
            result <= '0;
            exc    <= 1'b0;
            rdy    <= 1'b0;
        end else begin
            rdy <= 1'b0;
            if (start) begin
                // A start in any state, including mid-run, discards the current work.
                if (zero_div) begin
                    result <= '0;
                    exc    <= 1'b1;
                    rdy    <= 1'b1;
                end else begin
                    quo    <= abs_a;
                    dvs    <= {1'b0, abs_b};
                    rem    <= '0;
                    neg    <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                    cnt    <= '0;
                    result <= '0;
                    exc    <= 1'b0;
                end
            end else if (state == RUN) begin
                rem <= rem_new;
                quo <= quo_new;
                cnt <= cnt + CW'(1);
                if (last_iter) begin
                    result <= quo_signed;
                    exc    <= 1'b0;
                    rdy    <= 1'b1;
                end
            end
        end
    end

    assign bus.data_result    = result;
    assign bus.data_exception = exc;
    assign bus.data_resultRDY = rdy;
endmodule

// File: tb/tb_nonrestoring_div.sv
// Bench for nonrestoring_div: directed cases plus randomized operands against a
// plain-arithmetic signed division model.
module tb_nonrestoring_div;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    nonrestoring_div_if #(.WIDTH(32)) bus ();

    nonrestoring_div #(.WIDTH(32), .ITER(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic e, output int lat);
        longint la;
        longint lb;
        longint lq;
        if (b == 32'd0) begin
            q   = 32'd0;
            e   = 1'b1;
            lat = 1;
        end else begin
            la  = longint'($signed(a));
            lb  = longint'($signed(b));
            lq  = la / lb;
            q   = lq[31:0];
            e   = 1'b0;
            lat = 33;
        end
    endfunction

    // Call just after a falling edge; returns just after the start edge with the
    // operand ports scrambled so late sampling would show up.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        bus.ctrl_DIV      = 1'b1;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(posedge clock);
        #1;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output logic exc, output int cyc);
        start_op(a, b);
        cyc = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clock);
            if (bus.data_resultRDY) begin
                cyc = k;
                break;
            end
        end
        res = bus.data_result;
        exc = bus.data_exception;
    endtask

    task automatic test_reset();
        reset             = 1'b1;
        bus.ctrl_DIV      = 1'b1;
        bus.data_operandA = 32'd5;
        bus.data_operandB = 32'd0;
        repeat (3) @(negedge clock);
        total++; if (bus.data_result !== 32'd0) begin bad++; $display("FAIL reset_result: got %h want 0", bus.data_result); end
        total++; if (bus.data_exception !== 1'b0) begin bad++; $display("FAIL reset_exc: got %b want 0", bus.data_exception); end
        total++; if (bus.data_resultRDY !== 1'b0) begin bad++; $display("FAIL reset_rdy: got %b want 0", bus.data_resultRDY); end
        bus.ctrl_DIV = 1'b0;
        reset        = 1'b0;
        repeat (2) @(negedge clock);
        total++; if (bus.data_resultRDY !== 1'b0) begin bad++; $display("FAIL reset_release_rdy: got %b want 0", bus.data_resultRDY); end
    endtask

    task automatic test_basic();
        logic [31:0] res;
        logic        exc;
        int          cyc;
        run_div(32'd100, 32'd7, res, exc, cyc);
        total++; if (cyc !== 33) begin bad++; $display("FAIL basic_latency: got %0d want 33", cyc); end
        total++; if (res !== 32'h0000000E) begin bad++; $display("FAIL basic_result: got %h want 0000000e", res); end
        total++; if (exc !== 1'b0) begin bad++; $display("FAIL basic_exc: got %b want 0", exc); end
        @(negedge clock);
        total++; if (bus.data_resultRDY !== 1'b0) begin bad++; $display("FAIL basic_rdy_pulse: got %b want 0", bus.data_resultRDY); end
        total++; if (bus.data_result !== 32'h0000000E) begin bad++; $display("FAIL basic_hold: got %h want 0000000e", bus.data_result); end
    endtask

    task automatic test_signs();
        logic [31:0] tab_a [4] = '{-32'sd100, 32'd100, -32'sd100, 32'd7};
        logic [31:0] tab_b [4] = '{32'd7, -32'sd7, -32'sd7, -32'sd100};
        logic [31:0] tab_q [4] = '{32'hFFFFFFF2, 32'hFFFFFFF2, 32'h0000000E, 32'h00000000};
        logic [31:0] res;
        logic        exc;
        int          cyc;
        for (int i = 0; i < 4; i++) begin
            run_div(tab_a[i], tab_b[i], res, exc, cyc);
            total++; if (res !== tab_q[i]) begin bad++; $display("FAIL signs_result[%0d]: got %h want %h", i, res, tab_q[i]); end
            total++; if (cyc !== 33) begin bad++; $display("FAIL signs_latency[%0d]: got %0d want 33", i, cyc); end
            @(negedge clock);
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] res;
        logic        exc;
        int          cyc;
        run_div(32'd12345, 32'd0, res, exc, cyc);
        total++; if (cyc !== 1) begin bad++; $display("FAIL divzero_latency: got %0d want 1", cyc); end
        total++; if (res !== 32'd0) begin bad++; $display("FAIL divzero_result: got %h want 0", res); end
        total++; if (exc !== 1'b1) begin bad++; $display("FAIL divzero_exc: got %b want 1", exc); end
        @(negedge clock);
        total++; if (bus.data_resultRDY !== 1'b0) begin bad++; $display("FAIL divzero_rdy_pulse: got %b want 0", bus.data_resultRDY); end
        total++; if (bus.data_exception !== 1'b1) begin bad++; $display("FAIL divzero_exc_hold: got %b want 1", bus.data_exception); end
        run_div(32'd0, 32'd5, res, exc, cyc);
        total++; if (res !== 32'd0) begin bad++; $display("FAIL zero_dividend_result: got %h want 0", res); end
        total++; if (exc !== 1'b0) begin bad++; $display("FAIL zero_dividend_exc: got %b want 0", exc); end
        total++; if (cyc !== 33) begin bad++; $display("FAIL zero_dividend_latency: got %0d want 33", cyc); end
        @(negedge clock);
    endtask

    task automatic test_boundary();
        logic [31:0] tab_a [3] = '{32'h80000000, 32'h80000000, 32'h7FFFFFFF};
        logic [31:0] tab_b [3] = '{32'hFFFFFFFF, 32'h00000001, 32'h7FFFFFFF};
        logic [31:0] tab_q [3] = '{32'h80000000, 32'h80000000, 32'h00000001};
        logic [31:0] res;
        logic        exc;
        int          cyc;
        for (int i = 0; i < 3; i++) begin
            run_div(tab_a[i], tab_b[i], res, exc, cyc);
            total++; if (res !== tab_q[i]) begin bad++; $display("FAIL boundary_result[%0d]: got %h want %h", i, res, tab_q[i]); end
            total++; if (exc !== 1'b0) begin bad++; $display("FAIL boundary_exc[%0d]: got %b want 0", i, exc); end
            @(negedge clock);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] tab_a [3] = '{32'd1000, 32'd5, -32'sd9};
        logic [31:0] tab_b [3] = '{-32'sd10, 32'd0, 32'd2};
        logic [31:0] res;
        logic [31:0] exp_q;
        logic        exc;
        logic        exp_e;
        int          cyc;
        int          exp_lat;
        // Each new start is issued during the RDY cycle of the previous one.
        for (int i = 0; i < 3; i++) begin
            model(tab_a[i], tab_b[i], exp_q, exp_e, exp_lat);
            run_div(tab_a[i], tab_b[i], res, exc, cyc);
            total++; if (res !== exp_q) begin bad++; $display("FAIL b2b_result[%0d]: got %h want %h", i, res, exp_q); end
            total++; if (exc !== exp_e) begin bad++; $display("FAIL b2b_exc[%0d]: got %b want %b", i, exc, exp_e); end
            total++; if (cyc !== exp_lat) begin bad++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, cyc, exp_lat); end
        end
        @(negedge clock);
    endtask

    task automatic test_abort();
        logic [31:0] res;
        logic        exc;
        int          cyc;
        int          early;
        early = 0;
        start_op(32'd100, 32'd7);
        repeat (9) begin
            @(negedge clock);
            if (bus.data_resultRDY) early++;
        end
        run_div(32'd50, 32'd5, res, exc, cyc);
        total++; if (early !== 0) begin bad++; $display("FAIL abort_early_rdy: got %0d want 0", early); end
        total++; if (cyc !== 33) begin bad++; $display("FAIL abort_latency: got %0d want 33", cyc); end
        total++; if (res !== 32'd10) begin bad++; $display("FAIL abort_result: got %h want 0000000a", res); end
        @(negedge clock);
        total++; if (bus.data_resultRDY !== 1'b0) begin bad++; $display("FAIL abort_single_rdy: got %b want 0", bus.data_resultRDY); end
    endtask

    task automatic test_reset_midrun();
        logic [31:0] res;
        logic        exc;
        int          cyc;
        int          stray;
        stray = 0;
        start_op(32'd100, 32'd7);
        repeat (14) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        total++; if (bus.data_result !== 32'd0) begin bad++; $display("FAIL midreset_result: got %h want 0", bus.data_result); end
        total++; if (bus.data_exception !== 1'b0) begin bad++; $display("FAIL midreset_exc: got %b want 0", bus.data_exception); end
        total++; if (bus.data_resultRDY !== 1'b0) begin bad++; $display("FAIL midreset_rdy: got %b want 0", bus.data_resultRDY); end
        repeat (40) begin
            @(negedge clock);
            if (bus.data_resultRDY) stray++;
        end
        total++; if (stray !== 0) begin bad++; $display("FAIL midreset_stray_rdy: got %0d want 0", stray); end
        run_div(32'd9, 32'd3, res, exc, cyc);
        total++; if (res !== 32'd3) begin bad++; $display("FAIL midreset_next_result: got %h want 3", res); end
        total++; if (cyc !== 33) begin bad++; $display("FAIL midreset_next_latency: got %0d want 33", cyc); end
        @(negedge clock);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] exp_q;
        logic        exc;
        logic        exp_e;
        int          cyc;
        int          exp_lat;
        for (int i = 0; i < 150; i++) begin
            a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFFFFFF;
                2:       b = 32'($urandom_range(1, 20));
                3:       b = -32'($urandom_range(1, 20));
                4:       b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
            model(a, b, exp_q, exp_e, exp_lat);
            run_div(a, b, res, exc, cyc);
            total++; if (res !== exp_q) begin bad++; $display("FAIL rand_result: %h / %h got %h want %h", a, b, res, exp_q); end
            total++; if (exc !== exp_e) begin bad++; $display("FAIL rand_exc: %h / %h got %b want %b", a, b, exc, exp_e); end
            total++; if (cyc !== exp_lat) begin bad++; $display("FAIL rand_latency: %h / %h got %0d want %0d", a, b, cyc, exp_lat); end
            if ($urandom_range(0, 1) == 1) @(negedge clock);
        end
    endtask

    initial begin
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = 32'd0;
        bus.data_operandB = 32'd0;
        test_reset();
        test_basic();
        test_signs();
        test_div_zero();
        test_boundary();
        test_back_to_back();
        test_abort();
        test_reset_midrun();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nonrestoring_div.md
Name: nonrestoring_div

Overview:
- Sequential 32-bit signed integer divider for the multdiv unit.
- Runs a radix-2 non-restoring algorithm and issues one 33-bit add or subtract per cycle on its partial remainder.
- That add/subtract goes through the team's 33-bit carry-lookahead adder: subtract is A + ~B with Cin=1.
- Sits between pipeline operand latching and the multdiv result mux; reports completion through a one-cycle ready pulse.

Parameters:
- WIDTH, 32: operand and quotient width. The adder width is WIDTH+1.
- ITER, 32: number of iteration cycles. Must equal WIDTH.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- ctrl_DIV  input  1  start pulse. Operands are sampled on the edge where it is high.
- data_operandA  input  32  dividend, two's complement.
- data_operandB  input  32  divisor, two's complement.
- data_result  output  32  signed quotient, truncated toward zero.
- data_exception  output  1  divide-by-zero flag. Valid while data_resultRDY=1.
- data_resultRDY  output  1  one-cycle completion pulse.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE.
  - data_result=0, data_exception=0, data_resultRDY=0.
  - Counter, remainder R, quotient register Q and divisor register D all cleared.
  - Reset has priority over ctrl_DIV on the same edge.
- States: IDLE, RUN, DONE.
- IDLE, on an edge with ctrl_DIV=1:
  - If B==0: go to DONE. data_result=0, data_exception=1, data_resultRDY=1 in the following cycle, so latency is 1.
  - Otherwise latch:
    - Q = |A|.
    - D = {1'b0, |B|}.
    - R = 33'b0.
    - Sign flag s = A[31] ^ B[31].
    - Counter = 0.
    - Go to RUN.
  - |x| of 0x80000000 is 0x80000000 taken as unsigned. The 33-bit R holds it without overflow.
- RUN, each edge (one iteration):
  - Shift {R,Q} left by 1.
  - If the pre-shift R[32]==0, R = shifted R − D. Otherwise R = shifted R + D.
  - Q[0] = ~new R[32].
  - Counter increments.
  - On the edge that completes iteration ITER (counter == ITER-1):
    - data_result = s ? −Q : Q, taken mod 2^32.
    - data_exception = 0.
    - data_resultRDY = 1.
    - Go to DONE.
  - Normal latency: ctrl_DIV sample edge E0, iterations on edges E1..E32, RDY high during the cycle after E32.
- DONE:
  - data_resultRDY is high for exactly this one cycle, then returns to 0.
  - data_result and data_exception hold their values until the next start or reset.
  - Next edge goes to IDLE, or to RUN/DONE if ctrl_DIV=1 on that edge (back-to-back start allowed).
- ctrl_DIV=1 during RUN: abort the current division, relatch the new operands, restart at iteration 0. No RDY pulse for the aborted operation.
- Remainder: never corrected or output. Quotient bits from non-restoring iteration are exact without correction.
- Overflow case 0x80000000 / 0xFFFFFFFF: wraps to 0x80000000, data_exception=0.
- Signs:
  - Quotient sign = sign(A) XOR sign(B).
  - A zero quotient is always 0x00000000, never a negative zero.
- Operand ports are only sampled on the start edge. Changes at other times have no effect.
- data_exception is 0 on every normal completion.

Test Plan:
- A=100, B=7, start pulse -> RDY high exactly 33 cycles after the start edge (the cycle after E32); result=14 (0x0000000E), exception=0; RDY low on the next cycle.
- A=−100, B=7, then A=100, B=−7, then A=−100, B=−7 -> results 0xFFFFFFF2, 0xFFFFFFF2, 0x0000000E; A=7, B=−100 -> result 0.
- A=12345, B=0 -> RDY in the cycle after the start edge; result=0, exception=1. Then A=0, B=5 -> result 0, exception=0.
- A=0x80000000, B=0xFFFFFFFF -> 0x80000000. A=0x80000000, B=1 -> 0x80000000. A=0x7FFFFFFF, B=0x7FFFFFFF -> 1.
- Start 100/7, pulse ctrl_DIV again at cycle 10 with 50/5 -> single RDY 33 cycles after the second start, result=10.
- Assert reset at cycle 15 of a division -> all outputs 0 on the next cycle and no RDY pulse. A later start 9/3 completes normally with result 3.
